// File: rtl/regfile_port_arbiter.sv
// Two-requester front end for a 4x16 register file: round-robin grant, 1-cycle responses, sequenced clear.
// Define REGFILE_ARB_FIXED_PRIO_EN to make requester 0 always win contention.
module regfile_port_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int INDEX_WIDTH  = 2,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    output logic                   clear_busy,

    input  logic                   req_valid_0,
    output logic                   req_ready_0,
    input  logic                   req_write_0,
    input  logic [INDEX_WIDTH-1:0] req_index_0,
    input  logic [DATA_WIDTH-1:0]  req_data_0,
    output logic                   resp_valid_0,
    output logic [DATA_WIDTH-1:0]  resp_data_0,

    input  logic                   req_valid_1,
    output logic                   req_ready_1,
    input  logic                   req_write_1,
    input  logic [INDEX_WIDTH-1:0] req_index_1,
    input  logic [DATA_WIDTH-1:0]  req_data_1,
    output logic                   resp_valid_1,
    output logic [DATA_WIDTH-1:0]  resp_data_1,

    output logic                   rf_reset,
    output logic                   rf_write_enable,
    output logic [INDEX_WIDTH-1:0] rf_write_index,
    output logic [DATA_WIDTH-1:0]  rf_write_data,
    output logic [INDEX_WIDTH-1:0] rf_read_index_a,
    input  logic [DATA_WIDTH-1:0]  rf_read_data_a
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_clr_cnt;
    logic [CNT_W-1:0]       w_clr_cnt_next;

    logic                   w_grant_en;
    logic                   w_gnt_0;
    logic                   w_gnt_1;
    logic                   w_win_write;
    logic [INDEX_WIDTH-1:0] w_win_index;
    logic [DATA_WIDTH-1:0]  w_win_data;

    logic                   r_resp_valid_0;
    logic                   r_resp_valid_1;
    logic [DATA_WIDTH-1:0]  r_resp_data_0;
    logic [DATA_WIDTH-1:0]  r_resp_data_1;

    // A clear request in RUN takes the cycle: no op is accepted alongside it.
    assign w_grant_en = (r_state == ST_RUN) && !clear;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    assign w_gnt_0 = w_grant_en & req_valid_0;
    assign w_gnt_1 = w_grant_en & req_valid_1 & ~req_valid_0;
`else
    logic r_rr_ptr;

    assign w_gnt_0 = w_grant_en & req_valid_0 & (~req_valid_1 | ~r_rr_ptr);
    assign w_gnt_1 = w_grant_en & req_valid_1 & (~req_valid_0 |  r_rr_ptr);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
        end else if (w_gnt_0) begin
            r_rr_ptr <= 1'b1;
        end else if (w_gnt_1) begin
            r_rr_ptr <= 1'b0;
        end
    end
`endif

    // Fields default to requester 0 so the read index follows it when nobody is granted.
    assign w_win_write = w_gnt_1 ? req_write_1 : req_write_0;
    assign w_win_index = w_gnt_1 ? req_index_1 : req_index_0;
    assign w_win_data  = w_gnt_1 ? req_data_1  : req_data_0;

    assign req_ready_0     = w_gnt_0;
    assign req_ready_1     = w_gnt_1;
    assign rf_write_enable = (w_gnt_0 | w_gnt_1) & w_win_write;
    assign rf_write_index  = w_win_index;
    assign rf_write_data   = w_win_data;
    assign rf_read_index_a = w_win_index;

    assign rf_reset   = reset | (r_state == ST_CLEAR);
    assign clear_busy = (r_state == ST_CLEAR);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (clear) begin
                    w_state_next   = ST_CLEAR;
                    w_clr_cnt_next = '0;
                end
            end
            ST_CLEAR: begin
                if (r_clr_cnt == CNT_LAST) begin
                    w_state_next   = ST_RUN;
                    w_clr_cnt_next = '0;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next   = ST_RUN;
                w_clr_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    // Read data is captured at the accept edge, so a read right after a write sees the new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid_0 <= 1'b0;
            r_resp_valid_1 <= 1'b0;
            r_resp_data_0  <= '0;
            r_resp_data_1  <= '0;
        end else begin
            r_resp_valid_0 <= w_gnt_0;
            r_resp_valid_1 <= w_gnt_1;
            if (w_gnt_0) begin
                r_resp_data_0 <= req_write_0 ? req_data_0 : rf_read_data_a;
            end
            if (w_gnt_1) begin
                r_resp_data_1 <= req_write_1 ? req_data_1 : rf_read_data_a;
            end
        end
    end

    assign resp_valid_0 = r_resp_valid_0;
    assign resp_valid_1 = r_resp_valid_1;
    assign resp_data_0  = r_resp_data_0;
    assign resp_data_1  = r_resp_data_1;

    a_one_grant : assert property (@(posedge clk) disable iff (reset)
        !(req_ready_0 && req_ready_1));
    a_ready_0_needs_valid : assert property (@(posedge clk) disable iff (reset)
        req_ready_0 |-> req_valid_0);
    a_ready_1_needs_valid : assert property (@(posedge clk) disable iff (reset)
        req_ready_1 |-> req_valid_1);
    a_no_grant_in_clear : assert property (@(posedge clk) disable iff (reset)
        clear_busy |-> !(req_ready_0 || req_ready_1));

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed and random checks for regfile_port_arbiter against a behavioural register file.
module tb_regfile_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        clear_busy;
    logic        req_valid_0, req_ready_0, req_write_0;
    logic [1:0]  req_index_0;
    logic [15:0] req_data_0;
    logic        resp_valid_0;
    logic [15:0] resp_data_0;
    logic        req_valid_1, req_ready_1, req_write_1;
    logic [1:0]  req_index_1;
    logic [15:0] req_data_1;
    logic        resp_valid_1;
    logic [15:0] resp_data_1;
    logic        rf_reset, rf_write_enable;
    logic [1:0]  rf_write_index, rf_read_index_a;
    logic [15:0] rf_write_data, rf_read_data_a;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf_mem [4];

    regfile_port_arbiter #(
        .DATA_WIDTH  (16),
        .INDEX_WIDTH (2),
        .CLEAR_CYCLES(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .clear_busy     (clear_busy),
        .req_valid_0    (req_valid_0),
        .req_ready_0    (req_ready_0),
        .req_write_0    (req_write_0),
        .req_index_0    (req_index_0),
        .req_data_0     (req_data_0),
        .resp_valid_0   (resp_valid_0),
        .resp_data_0    (resp_data_0),
        .req_valid_1    (req_valid_1),
        .req_ready_1    (req_ready_1),
        .req_write_1    (req_write_1),
        .req_index_1    (req_index_1),
        .req_data_1     (req_data_1),
        .resp_valid_1   (resp_valid_1),
        .resp_data_1    (resp_data_1),
        .rf_reset       (rf_reset),
        .rf_write_enable(rf_write_enable),
        .rf_write_index (rf_write_index),
        .rf_write_data  (rf_write_data),
        .rf_read_index_a(rf_read_index_a),
        .rf_read_data_a (rf_read_data_a)
    );

    always #5 clk = ~clk;

    // Behavioural register file: synchronous reset, one write port, combinational read.
    always @(posedge clk) begin
        if (rf_reset) begin
            for (int i = 0; i < 4; i++) rf_mem[i] <= 16'h0000;
        end else if (rf_write_enable) begin
            rf_mem[rf_write_index] <= rf_write_data;
        end
    end
    assign rf_read_data_a = rf_mem[rf_read_index_a];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0;
        req_valid_0 = 1'b0; req_write_0 = 1'b0; req_index_0 = 2'd0; req_data_0 = 16'h0;
        req_valid_1 = 1'b0; req_write_1 = 1'b0; req_index_1 = 2'd0; req_data_1 = 16'h0;
        tick(); tick();
        checks++; if (rf_reset !== 1'b1) begin errors++; $display("FAIL reset_rf_reset got %b exp 1", rf_reset); end
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_clear_busy got %b exp 0", clear_busy); end
        checks++; if ({resp_valid_0, resp_valid_1} !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b exp 00", {resp_valid_0, resp_valid_1}); end
        checks++; if ({resp_data_0, resp_data_1} !== 32'h0) begin errors++; $display("FAIL reset_resp_data got %h exp 0", {resp_data_0, resp_data_1}); end
        reset = 1'b0;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1; req_index_1 = 2'd1;
        settle();
        checks++; if ({req_ready_0, req_ready_1} !== 2'b10) begin errors++; $display("FAIL reset_rr_pref got %b exp 10", {req_ready_0, req_ready_1}); end
        checks++; if (rf_reset !== 1'b0) begin errors++; $display("FAIL reset_rf_reset_rel got %b exp 0", rf_reset); end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        settle();
    endtask

    task automatic test_read_after_reset();
        req_valid_0 = 1'b1; req_write_0 = 1'b0; req_index_0 = 2'd2;
        settle();
        checks++; if ({req_ready_0, req_ready_1} !== 2'b10) begin errors++; $display("FAIL rd0_ready got %b exp 10", {req_ready_0, req_ready_1}); end
        checks++; if (rf_read_index_a !== 2'd2) begin errors++; $display("FAIL rd0_index got %0d exp 2", rf_read_index_a); end
        checks++; if (rf_write_enable !== 1'b0) begin errors++; $display("FAIL rd0_we got %b exp 0", rf_write_enable); end
        tick();
        req_valid_0 = 1'b0;
        checks++; if (resp_valid_0 !== 1'b1 || resp_data_0 !== 16'h0000) begin errors++; $display("FAIL rd0_resp got %b/%h exp 1/0000", resp_valid_0, resp_data_0); end
        checks++; if (resp_valid_1 !== 1'b0) begin errors++; $display("FAIL rd0_resp1 got %b exp 0", resp_valid_1); end
        tick();
        checks++; if (resp_valid_0 !== 1'b0) begin errors++; $display("FAIL rd0_pulse got %b exp 0", resp_valid_0); end
    endtask

    task automatic test_write_then_read();
        req_valid_0 = 1'b1; req_write_0 = 1'b1; req_index_0 = 2'd1; req_data_0 = 16'hBEEF;
        settle();
        checks++; if (req_ready_0 !== 1'b1) begin errors++; $display("FAIL wr_ready got %b exp 1", req_ready_0); end
        checks++; if ({rf_write_enable, rf_write_index, rf_write_data} !== {1'b1, 2'd1, 16'hBEEF}) begin
            errors++; $display("FAIL wr_port got %b/%0d/%h exp 1/1/beef", rf_write_enable, rf_write_index, rf_write_data); end
        tick();
        req_valid_0 = 1'b0; req_write_0 = 1'b0;
        req_valid_1 = 1'b1; req_write_1 = 1'b0; req_index_1 = 2'd1; req_data_1 = 16'h5555;
        settle();
        checks++; if (resp_valid_0 !== 1'b1 || resp_data_0 !== 16'hBEEF) begin errors++; $display("FAIL wr_echo got %b/%h exp 1/beef", resp_valid_0, resp_data_0); end
        checks++; if ({req_ready_0, req_ready_1, rf_read_index_a, rf_write_enable} !== {1'b0, 1'b1, 2'd1, 1'b0}) begin
            errors++; $display("FAIL rd1_issue got %b%b/%0d/%b exp 01/1/0", req_ready_0, req_ready_1, rf_read_index_a, rf_write_enable); end
        tick();
        req_valid_1 = 1'b0;
        checks++; if (resp_valid_1 !== 1'b1 || resp_data_1 !== 16'hBEEF) begin errors++; $display("FAIL rd1_resp got %b/%h exp 1/beef", resp_valid_1, resp_data_1); end
        checks++; if (resp_valid_0 !== 1'b0 || resp_data_0 !== 16'hBEEF) begin errors++; $display("FAIL resp0_hold got %b/%h exp 0/beef", resp_valid_0, resp_data_0); end
    endtask

    task automatic test_back_to_back();
        logic        exp_sel;
        logic [15:0] exp_data;
        int          n0;
        int          n1;
        n0 = 0; n1 = 0;
        req_valid_0 = 1'b1; req_write_0 = 1'b1; req_index_0 = 2'd0; req_data_0 = 16'hA000;
        req_valid_1 = 1'b1; req_write_1 = 1'b1; req_index_1 = 2'd2; req_data_1 = 16'hB000;
        for (int i = 0; i < 4; i++) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
            exp_sel = 1'b0;
`else
            exp_sel = (i % 2 == 1);
`endif
            exp_data = exp_sel ? req_data_1 : req_data_0;
            settle();
            checks++; if ({req_ready_0, req_ready_1} !== {~exp_sel, exp_sel}) begin
                errors++; $display("FAIL b2b_grant cycle %0d got %b%b exp %b%b", i, req_ready_0, req_ready_1, ~exp_sel, exp_sel); end
            tick();
            if (!exp_sel) begin
                checks++; if (resp_valid_0 !== 1'b1 || resp_data_0 !== exp_data) begin
                    errors++; $display("FAIL b2b_resp0 cycle %0d got %b/%h exp 1/%h", i, resp_valid_0, resp_data_0, exp_data); end
                n0++; req_data_0 = 16'hA000 + 16'(n0);
            end else begin
                checks++; if (resp_valid_1 !== 1'b1 || resp_data_1 !== exp_data) begin
                    errors++; $display("FAIL b2b_resp1 cycle %0d got %b/%h exp 1/%h", i, resp_valid_1, resp_data_1, exp_data); end
                n1++; req_data_1 = 16'hB000 + 16'(n1);
            end
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0; req_write_0 = 1'b0; req_write_1 = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        req_valid_0 = 1'b1; req_write_0 = 1'b1; req_index_0 = 2'd3; req_data_0 = 16'h1234;
        settle();
        checks++; if (req_ready_0 !== 1'b1) begin errors++; $display("FAIL clr_wr_ready got %b exp 1", req_ready_0); end
        tick();
        checks++; if (resp_valid_0 !== 1'b1 || resp_data_0 !== 16'h1234) begin errors++; $display("FAIL clr_wr_resp got %b/%h exp 1/1234", resp_valid_0, resp_data_0); end
        req_write_0 = 1'b0; clear = 1'b1;
        settle();
        checks++; if ({req_ready_0, req_ready_1, clear_busy, rf_reset} !== 4'b0000) begin
            errors++; $display("FAIL clr_req_cycle got %b%b%b%b exp 0000", req_ready_0, req_ready_1, clear_busy, rf_reset); end
        tick();
        settle();
        checks++; if ({clear_busy, rf_reset, req_ready_0, resp_valid_0} !== 4'b1100) begin
            errors++; $display("FAIL clr_cycle1 got %b%b%b%b exp 1100", clear_busy, rf_reset, req_ready_0, resp_valid_0); end
        tick();
        clear = 1'b0;
        settle();
        checks++; if ({clear_busy, rf_reset, req_ready_0} !== 3'b110) begin
            errors++; $display("FAIL clr_cycle2 got %b%b%b exp 110", clear_busy, rf_reset, req_ready_0); end
        tick();
        settle();
        checks++; if ({clear_busy, rf_reset, req_ready_0, rf_read_index_a} !== {3'b001, 2'd3}) begin
            errors++; $display("FAIL clr_exit got %b%b%b/%0d exp 001/3", clear_busy, rf_reset, req_ready_0, rf_read_index_a); end
        tick();
        req_valid_0 = 1'b0;
        checks++; if (resp_valid_0 !== 1'b1 || resp_data_0 !== 16'h0000) begin errors++; $display("FAIL clr_readback got %b/%h exp 1/0000", resp_valid_0, resp_data_0); end
    endtask

    task automatic test_reset_mid_clear();
        req_valid_0 = 1'b1; req_write_0 = 1'b0; req_index_0 = 2'd0;
        tick();
        req_valid_0 = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        settle();
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL mid_clr_busy got %b exp 1", clear_busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        checks++; if ({clear_busy, rf_reset, resp_valid_0, resp_valid_1} !== 4'b0000) begin
            errors++; $display("FAIL mid_clr_run got %b%b%b%b exp 0000", clear_busy, rf_reset, resp_valid_0, resp_valid_1); end
        checks++; if (resp_data_0 !== 16'h0000) begin errors++; $display("FAIL mid_clr_data got %h exp 0000", resp_data_0); end
        req_valid_0 = 1'b1; req_write_0 = 1'b1; req_index_0 = 2'd0; req_data_0 = 16'hCAFE;
        req_valid_1 = 1'b1; req_write_1 = 1'b0; req_index_1 = 2'd0;
        settle();
        checks++; if ({req_ready_0, req_ready_1} !== 2'b10) begin errors++; $display("FAIL mid_clr_rr got %b exp 10", {req_ready_0, req_ready_1}); end
        tick();
        req_valid_0 = 1'b0; req_write_0 = 1'b0;
        settle();
        checks++; if (resp_valid_0 !== 1'b1 || resp_data_0 !== 16'hCAFE || req_ready_1 !== 1'b1) begin
            errors++; $display("FAIL mid_clr_wr got %b/%h/%b exp 1/cafe/1", resp_valid_0, resp_data_0, req_ready_1); end
        tick();
        req_valid_1 = 1'b0;
        checks++; if (resp_valid_1 !== 1'b1 || resp_data_1 !== 16'hCAFE) begin errors++; $display("FAIL mid_clr_rd got %b/%h exp 1/cafe", resp_valid_1, resp_data_1); end
    endtask

    task automatic test_random();
        logic [15:0] sh [4];
        logic [15:0] e_rd0, e_rd1;
        bit          e_rv0, e_rv1;
        bit          m_clr, m_rr, ok, g0, g1;
        int          m_cnt, wait0, wait1;
        reset = 1'b1; clear = 1'b0; req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) sh[i] = 16'h0;
        e_rd0 = 16'h0; e_rd1 = 16'h0; e_rv0 = 1'b0; e_rv1 = 1'b0;
        m_clr = 1'b0; m_rr = 1'b0; m_cnt = 0; wait0 = 0; wait1 = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!req_valid_0 && $urandom_range(0, 9) < 7) begin
                req_valid_0 = 1'b1; req_write_0 = 1'($urandom_range(0, 1));
                req_index_0 = 2'($urandom_range(0, 3)); req_data_0 = 16'($urandom);
            end
            if (!req_valid_1 && $urandom_range(0, 9) < 7) begin
                req_valid_1 = 1'b1; req_write_1 = 1'($urandom_range(0, 1));
                req_index_1 = 2'($urandom_range(0, 3)); req_data_1 = 16'($urandom);
            end
            clear = ($urandom_range(0, 99) == 0);
            settle();
            ok = !m_clr && !clear;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
            g0 = ok && req_valid_0;
            g1 = ok && req_valid_1 && !req_valid_0;
`else
            g0 = ok && req_valid_0 && (!req_valid_1 || !m_rr);
            g1 = ok && req_valid_1 && (!req_valid_0 || m_rr);
`endif
            checks++; if ({req_ready_0, req_ready_1} !== {g0, g1}) begin
                errors++; $display("FAIL rnd_grant cyc %0d got %b%b exp %b%b", cyc, req_ready_0, req_ready_1, g0, g1); end
            checks++; if ({rf_reset, clear_busy} !== {m_clr, m_clr}) begin
                errors++; $display("FAIL rnd_clear cyc %0d got %b%b exp %b%b", cyc, rf_reset, clear_busy, m_clr, m_clr); end
`ifndef REGFILE_ARB_FIXED_PRIO_EN
            if (req_valid_0 && ok && !req_ready_0) wait0++; else if (req_ready_0) wait0 = 0;
            if (req_valid_1 && ok && !req_ready_1) wait1++; else if (req_ready_1) wait1 = 0;
            if (req_valid_0 || req_valid_1) begin
                checks++; if (wait0 > 1 || wait1 > 1) begin errors++; $display("FAIL rnd_starve cyc %0d got waits %0d/%0d exp <=1", cyc, wait0, wait1); end
            end
`endif
            e_rv0 = g0; e_rv1 = g1;
            if (g0) e_rd0 = req_write_0 ? req_data_0 : sh[req_index_0];
            if (g1) e_rd1 = req_write_1 ? req_data_1 : sh[req_index_1];
            if (m_clr) begin
                for (int i = 0; i < 4; i++) sh[i] = 16'h0;
            end else if (g0 && req_write_0) begin
                sh[req_index_0] = req_data_0;
            end else if (g1 && req_write_1) begin
                sh[req_index_1] = req_data_1;
            end
            if (m_clr) begin
                if (m_cnt == 1) begin m_clr = 1'b0; m_cnt = 0; end else m_cnt++;
            end else if (clear) begin
                m_clr = 1'b1; m_cnt = 0;
            end
            if (g0) m_rr = 1'b1; else if (g1) m_rr = 1'b0;
            tick();
            checks++; if ({resp_valid_0, resp_data_0} !== {e_rv0, e_rd0}) begin
                errors++; $display("FAIL rnd_resp0 cyc %0d got %b/%h exp %b/%h", cyc, resp_valid_0, resp_data_0, e_rv0, e_rd0); end
            checks++; if ({resp_valid_1, resp_data_1} !== {e_rv1, e_rd1}) begin
                errors++; $display("FAIL rnd_resp1 cyc %0d got %b/%h exp %b/%h", cyc, resp_valid_1, resp_data_1, e_rv1, e_rd1); end
            if (g0) req_valid_0 = 1'b0;
            if (g1) req_valid_1 = 1'b0;
        end
        clear = 1'b0; req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_then_read();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
